// File: rtl/n4by2_b2_idiv_arbiter_if.sv
// Request/result bundle between the two client FSMs and the divider sequencer.
// Each port is a four-phase level handshake: req rises with stable x/y, ack rises with results,
// req falls, ack falls; results then stay put until that port is granted again.
interface n4by2_b2_idiv_arbiter_if;
  logic       req_a;
  logic [3:0] x_a;
  logic [1:0] y_a;
  logic       ack_a;
  logic [1:0] q_a;
  logic [1:0] r_a;
  logic       no_idiv_a;

  logic       req_b;
  logic [3:0] x_b;
  logic [1:0] y_b;
  logic       ack_b;
  logic [1:0] q_b;
  logic [1:0] r_b;
  logic       no_idiv_b;

  logic       busy;
  logic [1:0] star;  // debug view of the sequencer state

  modport master (
    output req_a, x_a, y_a, req_b, x_b, y_b,
    input  ack_a, q_a, r_a, no_idiv_a, ack_b, q_b, r_b, no_idiv_b, busy, star
  );

  modport slave (
    input  req_a, x_a, y_a, req_b, x_b, y_b,
    output ack_a, q_a, r_a, no_idiv_a, ack_b, q_b, r_b, no_idiv_b, busy, star
  );
endinterface

// File: rtl/n4by2_b2_idiv_arbiter.sv
// Round-robin sequencer sharing one signed 4-by-2 divider between ports A and B.
// Operands are registered on grant, results registered one cycle later and held per port.

module n4by2_b2_idiv_sdiv (
  input  logic [3:0] i_x,
  input  logic [1:0] i_y,
  output logic [1:0] o_q,
  output logic [1:0] o_r,
  output logic       o_no_idiv
);
  logic signed [5:0] w_xs;
  logic signed [5:0] w_ys;
  logic signed [5:0] w_q;
  logic              w_yz;

  assign w_yz = (i_y == 2'b00);
  assign w_xs = {{2{i_x[3]}}, i_x};
  // A zero divisor is swapped for 1 only to keep the divide operator well defined.
  assign w_ys = w_yz ? 6'sd1 : {{4{i_y[1]}}, i_y};
  assign w_q  = w_xs / w_ys;

  assign o_no_idiv = w_yz || (w_q > 6'sd1) || (w_q < -6'sd2);
  assign o_q       = w_q[1:0];
  // r = x - q*y is exact, so its two low bits need only two-bit arithmetic.
  assign o_r       = i_x[1:0] - w_q[1:0] * i_y;
endmodule

module n4by2_b2_idiv_arbiter (
  input  logic                         clock,
  input  logic                         reset_,
  n4by2_b2_idiv_arbiter_if.slave       bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_ACK  = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  state_t     r_star;
  logic [3:0] r_x;
  logic [1:0] r_y;
  logic       r_gnt;   // 0 = A granted, 1 = B granted
  logic       r_last;  // 0 = A served last, 1 = B served last
  logic       r_busy;
  logic       r_ack_a, r_ack_b;
  logic [1:0] r_q_a, r_r_a, r_q_b, r_r_b;
  logic       r_no_a, r_no_b;

  logic [1:0] w_q;
  logic [1:0] w_r;
  logic       w_no;
  logic       w_gnt_a;

  n4by2_b2_idiv_sdiv u_div (
    .i_x       (r_x),
    .i_y       (r_y),
    .o_q       (w_q),
    .o_r       (w_r),
    .o_no_idiv (w_no)
  );

  assign w_gnt_a = bus.req_a && (!bus.req_b || r_last);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_star  <= S_IDLE;
      r_x     <= 4'b0000;
      r_y     <= 2'b00;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_busy  <= 1'b0;
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_q_a   <= 2'b00;
      r_r_a   <= 2'b00;
      r_no_a  <= 1'b0;
      r_q_b   <= 2'b00;
      r_r_b   <= 2'b00;
      r_no_b  <= 1'b0;
    end else begin
      case (r_star)
        S_IDLE: begin
          if (w_gnt_a) begin
            r_x    <= bus.x_a;
            r_y    <= bus.y_a;
            r_gnt  <= 1'b0;
            r_busy <= 1'b1;
            r_star <= S_CALC;
          end else if (bus.req_b) begin
            r_x    <= bus.x_b;
            r_y    <= bus.y_b;
            r_gnt  <= 1'b1;
            r_busy <= 1'b1;
            r_star <= S_CALC;
          end
        end
        S_CALC: begin
          if (!r_gnt) begin
            r_q_a   <= w_no ? 2'b00 : w_q;
            r_r_a   <= w_no ? 2'b00 : w_r;
            r_no_a  <= w_no;
            r_ack_a <= 1'b1;
          end else begin
            r_q_b   <= w_no ? 2'b00 : w_q;
            r_r_b   <= w_no ? 2'b00 : w_r;
            r_no_b  <= w_no;
            r_ack_b <= 1'b1;
          end
          r_last <= r_gnt;
          r_star <= S_ACK;
        end
        S_ACK: begin
          if (!r_gnt && !bus.req_a) begin
            r_ack_a <= 1'b0;
            r_busy  <= 1'b0;
            r_star  <= S_IDLE;
          end else if (r_gnt && !bus.req_b) begin
            r_ack_b <= 1'b0;
            r_busy  <= 1'b0;
            r_star  <= S_IDLE;
          end
        end
        default: begin
          r_busy <= 1'b0;
          r_star <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack_a     = r_ack_a;
  assign bus.q_a       = r_q_a;
  assign bus.r_a       = r_r_a;
  assign bus.no_idiv_a = r_no_a;
  assign bus.ack_b     = r_ack_b;
  assign bus.q_b       = r_q_b;
  assign bus.r_b       = r_r_b;
  assign bus.no_idiv_b = r_no_b;
  assign bus.busy      = r_busy;
  assign bus.star      = r_star;
endmodule

// File: tb/tb_n4by2_b2_idiv_arbiter.sv
// Bench for the two-port divider sequencer: directed plan, tie arbitration, reset and
// protocol-violation cases, then random concurrent traffic checked against a reference model.
module tb_n4by2_b2_idiv_arbiter;
  logic clock = 1'b0;
  logic reset_;
  always #5 clock = ~clock;

  n4by2_b2_idiv_arbiter_if bus ();

  n4by2_b2_idiv_arbiter dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q_a[$];
  logic [4:0] exp_q_b[$];
  int         order_q[$];
  logic [4:0] disp_a = 5'b0;
  logic [4:0] disp_b = 5'b0;
  logic       prev_ack_a = 1'b0;
  logic       prev_ack_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {no_idiv, q, r} from the divider rules: truncate toward zero, remainder follows dividend.
  function automatic logic [4:0] model(input logic [3:0] x, input logic [1:0] y);
    int xv, yv, ax, ay, qv, rv;
    logic [1:0] qb, rb;
    xv = $signed(x);
    yv = $signed(y);
    if (yv == 0) return 5'b1_00_00;
    ax = (xv < 0) ? -xv : xv;
    ay = (yv < 0) ? -yv : yv;
    qv = ax / ay;
    if ((xv < 0) != (yv < 0)) qv = -qv;
    rv = xv - qv * yv;
    if (qv < -2 || qv > 1) return 5'b1_00_00;
    qb = qv[1:0];
    rb = rv[1:0];
    return {1'b0, qb, rb};
  endfunction

  // Monitor: pops an expectation on each ack rise and holds the per-port displayed result.
  always @(negedge clock) begin
    if (!reset_) begin
      disp_a = 5'b0;
      disp_b = 5'b0;
      prev_ack_a = 1'b0;
      prev_ack_b = 1'b0;
    end else begin
      if (bus.ack_a && !prev_ack_a) begin
        if (exp_q_a.size() == 0) check("unexpected_ack_a", 1, 0);
        else disp_a = exp_q_a.pop_front();
        order_q.push_back(0);
      end
      if (bus.ack_b && !prev_ack_b) begin
        if (exp_q_b.size() == 0) check("unexpected_ack_b", 1, 0);
        else disp_b = exp_q_b.pop_front();
        order_q.push_back(1);
      end
      check("result_a", {bus.no_idiv_a, bus.q_a, bus.r_a}, disp_a);
      check("result_b", {bus.no_idiv_b, bus.q_b, bus.r_b}, disp_b);
      check("ack_exclusive", bus.ack_a & bus.ack_b, 0);
      if (bus.ack_a || bus.ack_b) check("busy_with_ack", bus.busy, 1);
      prev_ack_a = bus.ack_a;
      prev_ack_b = bus.ack_b;
    end
  end

  task automatic txn(input bit p, input logic [3:0] x, input logic [1:0] y,
                     input int hold, output int lat);
    lat = 0;
    if (!p) begin
      bus.x_a = x; bus.y_a = y; bus.req_a = 1'b1;
      exp_q_a.push_back(model(x, y));
      while (!bus.ack_a && lat < 60) begin @(negedge clock); lat++; end
      check("ack_a_timeout", bus.ack_a, 1);
    end else begin
      bus.x_b = x; bus.y_b = y; bus.req_b = 1'b1;
      exp_q_b.push_back(model(x, y));
      while (!bus.ack_b && lat < 60) begin @(negedge clock); lat++; end
      check("ack_b_timeout", bus.ack_b, 1);
    end
    repeat (hold) @(negedge clock);
    if (!p) begin
      bus.req_a = 1'b0;
      bus.x_a = 4'($urandom_range(0, 15));
      bus.y_a = 2'($urandom_range(0, 3));
      for (int i = 0; i < 60 && bus.ack_a; i++) @(negedge clock);
      check("ack_a_release", bus.ack_a, 0);
    end else begin
      bus.req_b = 1'b0;
      bus.x_b = 4'($urandom_range(0, 15));
      bus.y_b = 2'($urandom_range(0, 3));
      for (int i = 0; i < 60 && bus.ack_b; i++) @(negedge clock);
      check("ack_b_release", bus.ack_b, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_port_a"}, {bus.ack_a, bus.no_idiv_a, bus.q_a, bus.r_a}, 0);
    check({tag, "_port_b"}, {bus.ack_b, bus.no_idiv_b, bus.q_b, bus.r_b}, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset_ = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [3:0] rx;
    logic [1:0] ry;
    reset_ = 1'b0;
    bus.req_a = 1'b0; bus.x_a = 4'b0; bus.y_a = 2'b0;
    bus.req_b = 1'b0; bus.x_b = 4'b0; bus.y_b = 2'b0;
    do_reset();

    // Directed plan: single-port latency is two edges from the sampled req.
    txn(0, 4'b0001, 2'b01, 1, lat);
    check("lat_a_basic", lat, 2);
    check("tp_basic_a", {bus.no_idiv_a, bus.q_a, bus.r_a}, 5'b0_01_00);
    check("tp_basic_ack_b", bus.ack_b, 0);
    txn(1, 4'b1101, 2'b10, 0, lat);
    check("lat_b_neg", lat, 2);
    check("tp_neg_b", {bus.no_idiv_b, bus.q_b, bus.r_b}, 5'b0_01_11);
    txn(1, 4'b0100, 2'b10, 2, lat);
    check("tp_m2_b", {bus.no_idiv_b, bus.q_b, bus.r_b}, 5'b0_10_00);
    txn(0, 4'b0011, 2'b01, 1, lat);
    check("tp_ovf_a", {bus.no_idiv_a, bus.q_a, bus.r_a}, 5'b1_00_00);
    txn(0, 4'($urandom_range(0, 15)), 2'b00, 1, lat);
    check("tp_div0_a", bus.no_idiv_a, 1);
    txn(0, 4'b1100, 2'b10, 1, lat);
    check("tp_pos2_a", {bus.no_idiv_a, bus.q_a, bus.r_a}, 5'b1_00_00);
    check("idle_busy", bus.busy, 0);

    // Tie arbitration after reset: A first, then strict alternation.
    do_reset();
    order_q.delete();
    fork
      begin
        for (int i = 0; i < 2; i++) begin
          int l;
          txn(0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1, l);
        end
      end
      begin
        for (int i = 0; i < 2; i++) begin
          int l;
          txn(1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1, l);
        end
      end
    join
    check("order_count", order_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      int got;
      got = (i < order_q.size()) ? order_q[i] : -1;
      check("order_alternate", got, i % 2);
    end

    // Reset while A is in CALC: everything drops at once, held req is served again.
    @(negedge clock);
    rx = 4'b0110; ry = 2'b11;
    bus.x_a = rx; bus.y_a = ry; bus.req_a = 1'b1;
    exp_q_a.push_back(model(rx, ry));
    @(posedge clock); #1;
    check("calc_busy", bus.busy, 1);
    reset_ = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clock); #1;
    reset_ = 1'b1;
    lat = 0;
    while (!bus.ack_a && lat < 60) begin @(negedge clock); lat++; end
    check("lat_after_reset", lat, 2);
    bus.req_a = 1'b0;
    for (int i = 0; i < 60 && bus.ack_a; i++) @(negedge clock);
    check("release_after_reset", bus.ack_a, 0);

    // Protocol violation: req_a dropped right after its grant edge.
    @(negedge clock);
    rx = 4'b1011; ry = 2'b11;
    bus.x_a = rx; bus.y_a = ry; bus.req_a = 1'b1;
    exp_q_a.push_back(model(rx, ry));
    @(posedge clock); #1;
    check("viol_calc", {bus.busy, bus.ack_a}, 2'b10);
    @(negedge clock);
    bus.req_a = 1'b0;
    @(posedge clock); #1;
    check("viol_ack", {bus.busy, bus.ack_a}, 2'b11);
    @(posedge clock); #1;
    check("viol_idle", {bus.busy, bus.ack_a}, 2'b00);
    @(negedge clock);

    // Random concurrent traffic on both ports.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          int l;
          repeat ($urandom_range(0, 4)) @(negedge clock);
          txn(0, 4'($urandom), 2'($urandom), $urandom_range(0, 3), l);
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          int l;
          repeat ($urandom_range(0, 4)) @(negedge clock);
          txn(1, 4'($urandom), 2'($urandom), $urandom_range(0, 3), l);
        end
      end
    join
    repeat (3) @(negedge clock);
    check("end_busy", bus.busy, 0);
    check("exp_a_empty", exp_q_a.size(), 0);
    check("exp_b_empty", exp_q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
